sap_control_sequencer: RTL and testbench

- Microcoded control unit for the SAP-1 datapath. Replaces the hand-driven virtual-IO control sources with generated control strobes.
- Steps a T-state counter once per one-shot step pulse and decodes the IR opcode into per-T-state bus/latch/enable strobes for PC, MAR/RAM, IR, A, B, ALU and output register.
- The datapath registers consume these strobes; the sequencer produces them.

---
 rtl/sap_pkg.sv | 62 ++++++
 rtl/sap_microcode_rom.sv | 84 ++++++++
 rtl/sap_control_sequencer.sv | 128 ++++++++++++
 tb/tb_sap_control_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg -- shared definitions for the SAP-1 control sequencer.
//   * opcode encodings (OP_NOP .. OP_HLT)
//   * control-word bit indices and the 15-bit ctrl_word_t
//   * T-state enumeration
//   * canned control words used by the microcode ROM and the sequencer
// ---------------------------------------------------------------------------
package sap_pkg;

    localparam int unsigned T_MAX_DEF = 5;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions inside the control word. Bit 14 is the halt marker: it is
    // never a datapath strobe, the sequencer uses it as its sticky halt flag.
    localparam int CW_W         = 15;
    localparam int CW_HLT       = 14;
    localparam int CW_PC_OUT    = 13;
    localparam int CW_PC_INC    = 12;
    localparam int CW_PC_JUMP   = 11;
    localparam int CW_MAR_LOAD  = 10;
    localparam int CW_RAM_OUT   = 9;
    localparam int CW_RAM_WRITE = 8;
    localparam int CW_IR_LATCH  = 7;
    localparam int CW_IR_OUT    = 6;
    localparam int CW_A_LATCH   = 5;
    localparam int CW_A_OUT     = 4;
    localparam int CW_B_LATCH   = 3;
    localparam int CW_ALU_OUT   = 2;
    localparam int CW_ALU_SUB   = 1;
    localparam int CW_OUT_LATCH = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    function automatic ctrl_word_t cw_bit(input int unsigned idx);
        return ctrl_word_t'(1) << idx;
    endfunction

    localparam ctrl_word_t CW_FETCH0 = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
    localparam ctrl_word_t CW_FETCH1 = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LATCH)
                                     | cw_bit(CW_PC_INC);
    localparam ctrl_word_t CW_HALT   = cw_bit(CW_HLT);

endpackage

// File: rtl/sap_microcode_rom.sv
// ---------------------------------------------------------------------------
// sap_microcode_rom -- combinational microcode lookup.
// Given the opcode in effect and the current T-state, returns the control
// word of the following T-state and whether the current state is the last
// active one of the instruction (in which case the word returned is T0).
//
// Ports:
//   opcode_i    in  4   opcode in effect (live at T1, registered afterwards)
//   tstate_i    in  3   current T-state
//   c_flag_i    in  1   carry flag (conditional jumps only)
//   z_flag_i    in  1   zero flag (conditional jumps only)
//   next_word_o out 15  control word for the next T-state
//   last_o      out 1   current T-state ends the instruction
//
// Build option: define SAP_COND_JUMP_EN to decode JC (7) and JZ (8);
// otherwise both fall through as NOP.
// ---------------------------------------------------------------------------
import sap_pkg::*;

module sap_microcode_rom #(
    parameter logic [3:0] HLT_OPCODE = OP_HLT
) (
    input  logic [3:0] opcode_i,
    input  tstate_e    tstate_i,
    input  logic       c_flag_i,
    input  logic       z_flag_i,
    output ctrl_word_t next_word_o,
    output logic       last_o
);

    localparam ctrl_word_t W_ADDR = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
    localparam ctrl_word_t W_JUMP = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_JUMP);

`ifndef SAP_COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = c_flag_i ^ z_flag_i;
`endif

    always_comb begin
        next_word_o = CW_FETCH0;
        last_o      = 1'b0;
        case (tstate_i)
            T0: next_word_o = CW_FETCH1;
            T1: begin
                if (opcode_i == HLT_OPCODE) begin
                    next_word_o = CW_HALT;
                end else begin
                    case (opcode_i)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: next_word_o = W_ADDR;
                        OP_LDI: next_word_o = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LATCH);
                        OP_JMP: next_word_o = W_JUMP;
                        OP_OUT: next_word_o = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LATCH);
`ifdef SAP_COND_JUMP_EN
                        // Flag is sampled here, at the step entering T2.
                        OP_JC: next_word_o = c_flag_i ? W_JUMP : '0;
                        OP_JZ: next_word_o = z_flag_i ? W_JUMP : '0;
`endif
                        default: last_o = 1'b1;
                    endcase
                end
            end
            T2: begin
                case (opcode_i)
                    OP_LDA: next_word_o = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LATCH);
                    OP_ADD: next_word_o = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LATCH);
                    OP_SUB: next_word_o = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LATCH)
                                        | cw_bit(CW_ALU_SUB);
                    OP_STA: next_word_o = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_WRITE);
                    default: last_o = 1'b1;
                endcase
            end
            T3: begin
                case (opcode_i)
                    OP_ADD: next_word_o = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LATCH);
                    OP_SUB: next_word_o = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LATCH)
                                        | cw_bit(CW_ALU_SUB);
                    default: last_o = 1'b1;
                endcase
            end
            default: last_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap_control_sequencer -- SAP-1 microcoded control unit.
// Advances a T-state counter on each one-shot step pulse and registers the
// control strobes for the new T-state on the same edge. HLT freezes the
// sequencer (tstate=2, strobes 0) until rst_n.
//
// Ports:
//   clk, rst_n (async, active low), step (one-clk qualifier)
//   opcode[3:0], c_flag, z_flag           decode inputs
//   pc_out_en, pc_inc, pc_jump            program counter controls
//   mar_load, ram_out, ram_write          MAR / RAM controls
//   ir_latch, ir_out                      instruction register controls
//   a_latch, a_out, b_latch               A / B register controls
//   alu_out, alu_sub                      ALU controls
//   out_latch                             output register latch
//   halted                                sticky halt indicator
//   tstate[2:0]                           current T-state
//
// Build option: SAP_COND_JUMP_EN enables JC/JZ decode (see sap_microcode_rom).
// ---------------------------------------------------------------------------
import sap_pkg::*;

module sap_control_sequencer #(
    parameter int unsigned T_MAX      = T_MAX_DEF,
    parameter logic [3:0]  HLT_OPCODE = OP_HLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [3:0] opcode,
    input  logic       c_flag,
    input  logic       z_flag,
    output logic       pc_out_en,
    output logic       pc_inc,
    output logic       pc_jump,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_write,
    output logic       ir_latch,
    output logic       ir_out,
    output logic       a_latch,
    output logic       a_out,
    output logic       b_latch,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_latch,
    output logic       halted,
    output logic [2:0] tstate
);

    localparam tstate_e T_LAST = tstate_e'(T_MAX - 1);

    tstate_e    tstate_q, tstate_d;
    ctrl_word_t ctrl_q, ctrl_d;
    logic [3:0] opcode_q, opcode_d;
    logic       armed_q;
    logic [3:0] op_eff;
    ctrl_word_t rom_word;
    logic       rom_last;
    logic       advance;

    // The live opcode only matters on the step leaving T1; afterwards the
    // copy captured at that step is used so IR changes cannot corrupt T2..T4.
    assign op_eff = (tstate_q == T1) ? opcode : opcode_q;

    // armed_q blocks a step that lands on the first edge after reset release.
    // The halt marker in the registered word doubles as the sticky halt flag.
    assign advance = step & armed_q & ~ctrl_q[CW_HLT];

    sap_microcode_rom #(
        .HLT_OPCODE (HLT_OPCODE)
    ) u_rom (
        .opcode_i    (op_eff),
        .tstate_i    (tstate_q),
        .c_flag_i    (c_flag),
        .z_flag_i    (z_flag),
        .next_word_o (rom_word),
        .last_o      (rom_last)
    );

    always_comb begin
        tstate_d = tstate_q;
        ctrl_d   = ctrl_q;
        opcode_d = opcode_q;
        if (advance) begin
            opcode_d = op_eff;
            if (rom_last || (tstate_q == T_LAST)) begin
                tstate_d = T0;
                ctrl_d   = CW_FETCH0;
            end else begin
                tstate_d = tstate_e'(tstate_q + 3'd1);
                ctrl_d   = rom_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate_q <= T0;
            ctrl_q   <= CW_FETCH0;
            opcode_q <= OP_NOP;
            armed_q  <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            ctrl_q   <= ctrl_d;
            opcode_q <= opcode_d;
            armed_q  <= 1'b1;
        end
    end

    assign pc_out_en = ctrl_q[CW_PC_OUT];
    assign pc_inc    = ctrl_q[CW_PC_INC];
    assign pc_jump   = ctrl_q[CW_PC_JUMP];
    assign mar_load  = ctrl_q[CW_MAR_LOAD];
    assign ram_out   = ctrl_q[CW_RAM_OUT];
    assign ram_write = ctrl_q[CW_RAM_WRITE];
    assign ir_latch  = ctrl_q[CW_IR_LATCH];
    assign ir_out    = ctrl_q[CW_IR_OUT];
    assign a_latch   = ctrl_q[CW_A_LATCH];
    assign a_out     = ctrl_q[CW_A_OUT];
    assign b_latch   = ctrl_q[CW_B_LATCH];
    assign alu_out   = ctrl_q[CW_ALU_OUT];
    assign alu_sub   = ctrl_q[CW_ALU_SUB];
    assign out_latch = ctrl_q[CW_OUT_LATCH];
    assign halted    = ctrl_q[CW_HLT];
    assign tstate    = tstate_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sap_control_sequencer -- directed self-checking bench for the SAP-1
// control sequencer. Observed strobes are packed in the order
// {pc_out_en,pc_inc,pc_jump,mar_load,ram_out,ram_write,ir_latch,ir_out,
//  a_latch,a_out,b_latch,alu_out,alu_sub,out_latch}.
// ---------------------------------------------------------------------------
module tb_sap_control_sequencer;

    localparam logic [13:0] S_PCO = 14'h2000;
    localparam logic [13:0] S_PCI = 14'h1000;
    localparam logic [13:0] S_PCJ = 14'h0800;
    localparam logic [13:0] S_MAR = 14'h0400;
    localparam logic [13:0] S_RO  = 14'h0200;
    localparam logic [13:0] S_RW  = 14'h0100;
    localparam logic [13:0] S_IRL = 14'h0080;
    localparam logic [13:0] S_IRO = 14'h0040;
    localparam logic [13:0] S_AL  = 14'h0020;
    localparam logic [13:0] S_AO  = 14'h0010;
    localparam logic [13:0] S_BL  = 14'h0008;
    localparam logic [13:0] S_ALU = 14'h0004;
    localparam logic [13:0] S_SUB = 14'h0002;
    localparam logic [13:0] S_OUT = 14'h0001;

    localparam logic [13:0] W_T0  = S_PCO | S_MAR;
    localparam logic [13:0] W_T1  = S_RO | S_IRL | S_PCI;
    localparam logic [13:0] BUS_M = S_PCO | S_RO | S_IRO | S_AO | S_ALU;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic [3:0] opcode = 4'h1;
    logic       c_flag = 1'b0;
    logic       z_flag = 1'b0;
    logic       pc_out_en, pc_inc, pc_jump, mar_load, ram_out, ram_write;
    logic       ir_latch, ir_out, a_latch, a_out, b_latch, alu_out, alu_sub;
    logic       out_latch, halted;
    logic [2:0] tstate;

    int tests_run = 0;
    int tests_failed = 0;

    sap_control_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .opcode    (opcode),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .pc_out_en (pc_out_en),
        .pc_inc    (pc_inc),
        .pc_jump   (pc_jump),
        .mar_load  (mar_load),
        .ram_out   (ram_out),
        .ram_write (ram_write),
        .ir_latch  (ir_latch),
        .ir_out    (ir_out),
        .a_latch   (a_latch),
        .a_out     (a_out),
        .b_latch   (b_latch),
        .alu_out   (alu_out),
        .alu_sub   (alu_sub),
        .out_latch (out_latch),
        .halted    (halted),
        .tstate    (tstate)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs_word();
        return {pc_out_en, pc_inc, pc_jump, mar_load, ram_out, ram_write,
                ir_latch, ir_out, a_latch, a_out, b_latch, alu_out, alu_sub,
                out_latch};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Full observable state: T-state, strobes, halted, single-bus-driver rule.
    task automatic check_state(input string tag, input int ts,
                               input logic [13:0] w, input logic h);
        check({tag, ".tstate"}, 32'(tstate), 32'(ts));
        check({tag, ".word"}, 32'(obs_word()), 32'(w));
        check({tag, ".halted"}, 32'(halted), 32'(h));
        check({tag, ".onebus"}, 32'($countones(obs_word() & BUS_M) <= 1), 32'd1);
    endtask

    // One step pulse; returns at the falling edge after the consuming posedge.
    task automatic pulse_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // Runs one instruction from T0: T1, n_exec execute states, back to T0.
    // The opcode is scrambled after entering T2 to prove it was captured.
    task automatic run_instr(input string name, input logic [3:0] op,
                             input int n_exec, input logic [13:0] w2,
                             input logic [13:0] w3, input logic [13:0] w4);
        logic [13:0] exp_w;
        opcode = op;
        pulse_step();
        check_state({name, ".T1"}, 1, W_T1, 1'b0);
        for (int t = 0; t < n_exec; t++) begin
            pulse_step();
            if (t == 0) opcode = ~op;
            exp_w = (t == 0) ? w2 : (t == 1) ? w3 : w4;
            check_state($sformatf("%s.T%0d", name, t + 2), t + 2, exp_w, 1'b0);
        end
        pulse_step();
        check_state({name, ".end"}, 0, W_T0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset with opcode=1 and no step.
        repeat (3) @(negedge clk);
        check_state("reset", 0, W_T0, 1'b0);

        // Step coinciding with reset release is ignored.
        step = 1'b1;
        #4 rst_n = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check_state("rel_step", 0, W_T0, 1'b0);

        // Strobes stay stable without a step.
        repeat (3) @(negedge clk);
        check_state("idle", 0, W_T0, 1'b0);

        run_instr("LDA", 4'h1, 2, S_IRO | S_MAR, S_RO | S_AL, 14'h0);
        run_instr("ADD", 4'h2, 3, S_IRO | S_MAR, S_RO | S_BL, S_ALU | S_AL);
        run_instr("SUB", 4'h3, 3, S_IRO | S_MAR, S_RO | S_BL | S_SUB,
                  S_ALU | S_AL | S_SUB);
        run_instr("STA", 4'h4, 2, S_IRO | S_MAR, S_AO | S_RW, 14'h0);
        run_instr("LDI", 4'h5, 1, S_IRO | S_AL, 14'h0, 14'h0);
        run_instr("JMP", 4'h6, 1, S_IRO | S_PCJ, 14'h0, 14'h0);
        run_instr("OUT", 4'hE, 1, S_AO | S_OUT, 14'h0, 14'h0);
        run_instr("NOP", 4'h0, 0, 14'h0, 14'h0, 14'h0);
        run_instr("UND9", 4'h9, 0, 14'h0, 14'h0, 14'h0);

`ifdef SAP_COND_JUMP_EN
        z_flag = 1'b1;
        run_instr("JZ_z1", 4'h8, 1, S_IRO | S_PCJ, 14'h0, 14'h0);
        z_flag = 1'b0;
        run_instr("JZ_z0", 4'h8, 1, 14'h0, 14'h0, 14'h0);
        c_flag = 1'b1;
        run_instr("JC_c1", 4'h7, 1, S_IRO | S_PCJ, 14'h0, 14'h0);
        c_flag = 1'b0;
`else
        z_flag = 1'b1;
        run_instr("JZ_nomacro", 4'h8, 0, 14'h0, 14'h0, 14'h0);
        c_flag = 1'b1;
        run_instr("JC_nomacro", 4'h7, 0, 14'h0, 14'h0, 14'h0);
        z_flag = 1'b0;
        c_flag = 1'b0;
`endif

        // HLT: freeze at T2 with strobes 0 until reset.
        opcode = 4'hF;
        pulse_step();
        check_state("HLT.T1", 1, W_T1, 1'b0);
        pulse_step();
        check_state("HLT.T2", 2, 14'h0, 1'b1);
        for (int i = 0; i < 10; i++) pulse_step();
        check_state("HLT.held", 2, 14'h0, 1'b1);
        reset_pulse();
        check_state("HLT.reset", 0, W_T0, 1'b0);

        // Asynchronous reset mid-T3 of ADD.
        opcode = 4'h2;
        pulse_step();
        pulse_step();
        pulse_step();
        check_state("ADDrst.T3", 3, S_RO | S_BL, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_state("ADDrst.async", 0, W_T0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step = 1'b1;
        #2;
        check_state("ADDrst.noedge", 0, W_T0, 1'b0);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Normal operation resumes after the reset.
        run_instr("LDA2", 4'h1, 2, S_IRO | S_MAR, S_RO | S_AL, 14'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net: the directed sequence needs well under this many cycles.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

endmodule
